// File: rtl/input_capture_unit.sv
// -----------------------------------------------------------------------------
// input_capture_unit
//
// Captures the live time-base counter into ccr_o on selected edges of an
// asynchronous timer input (or on a software request). It also maintains the
// sticky capture and overcapture flags.
//
// Optional feature macro: IC_FILTER_EN
//   defined   -> digital filter of length icf_i between synchronizer and
//                edge detector
//   undefined -> no filter hardware, icf_i ignored
//
// Ports
//   clk_i       single clock, rising edge
//   reset_i     synchronous active-high reset
//   cnt_i       live counter value (CNT_WIDTH)
//   ti_i        external timer input, asynchronous to clk_i
//   cce_i       capture enable
//   ccp_i       edge select: 00 rise, 01 fall, 11 both, 10 rise
//   icps_i      event prescaler: capture every 1/2/4/8 qualified edges
//   icf_i       filter length N (IC_FILTER_EN only)
//   ccg_i       software capture request pulse
//   ccif_clr_i  capture flag clear pulse
//   ccof_clr_i  overcapture flag clear pulse
//   ccr_o       captured counter value
//   ccif_o      sticky capture flag
//   ccof_o      sticky overcapture flag
//   capture_o   one-cycle pulse per capture
// -----------------------------------------------------------------------------
module input_capture_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 ti_i,
  input  logic                 cce_i,
  input  logic [1:0]           ccp_i,
  input  logic [1:0]           icps_i,
  input  logic [3:0]           icf_i,
  input  logic                 ccg_i,
  input  logic                 ccif_clr_i,
  input  logic                 ccof_clr_i,
  output logic [CNT_WIDTH-1:0] ccr_o,
  output logic                 ccif_o,
  output logic                 ccof_o,
  output logic                 capture_o
);

  logic       sync_p0;
  logic       sync_p1;
  logic       lvl;
  logic       lvl_prev_p2;
  logic       rise;
  logic       fall;
  logic       qual;
  logic       cap;
  logic [2:0] psc_cnt;
  logic [2:0] psc_nxt;
  logic [2:0] div_m1;

  // Qualify an edge according to the edge-select field (10 behaves as 00).
  function automatic logic edge_qual(input logic [1:0] sel,
                                     input logic       r,
                                     input logic       f);
    case (sel)
      2'b01:   return f;
      2'b11:   return r | f;
      default: return r;
    endcase
  endfunction

  // Prescaler terminal value: divisor-1 for divisors 1/2/4/8.
  function automatic logic [2:0] psc_limit(input logic [1:0] ps);
    case (ps)
      2'b00:   return 3'd0;
      2'b01:   return 3'd1;
      2'b10:   return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // ---- stage p0/p1: two-flop synchronizer for the asynchronous input ----
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= ti_i;
      sync_p1 <= sync_p0;
    end
  end

`ifdef IC_FILTER_EN
  // ---- filter: level follows sync_p1 only after N stable mismatching cycles ----
  logic       flt_lvl;
  logic [3:0] flt_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flt_lvl <= 1'b0;
      flt_cnt <= 4'd0;
    end else if (icf_i == 4'd0) begin
      // Track the input so that re-enabling the filter starts from a clean state.
      flt_lvl <= sync_p1;
      flt_cnt <= 4'd0;
    end else if (sync_p1 == flt_lvl) begin
      flt_cnt <= 4'd0;
    end else if (flt_cnt == icf_i - 4'd1) begin
      flt_lvl <= sync_p1;
      flt_cnt <= 4'd0;
    end else begin
      flt_cnt <= flt_cnt + 4'd1;
    end
  end

  assign lvl = (icf_i == 4'd0) ? sync_p1 : flt_lvl;
`else
  logic unused_icf;
  assign unused_icf = ^icf_i;
  assign lvl        = sync_p1;
`endif

  always_comb begin
    rise    = lvl & ~lvl_prev_p2;
    fall    = ~lvl & lvl_prev_p2;
    qual    = edge_qual(ccp_i, rise, fall);
    div_m1  = psc_limit(icps_i);
    cap     = 1'b0;
    psc_nxt = psc_cnt;
    if (!cce_i) begin
      psc_nxt = 3'd0;
    end else if (ccg_i) begin
      // Software request wins and absorbs any coincident hardware edge.
      cap     = 1'b1;
      psc_nxt = 3'd0;
    end else if (qual) begin
      // ">=" lets a shrunk divisor capture on the very next qualified edge.
      if (psc_cnt >= div_m1) begin
        cap     = 1'b1;
        psc_nxt = 3'd0;
      end else begin
        psc_nxt = psc_cnt + 3'd1;
      end
    end
  end

  // ---- stage p2: previous level, prescaler, capture register and flags ----
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lvl_prev_p2 <= 1'b0;
      psc_cnt     <= 3'd0;
      capture_o   <= 1'b0;
      ccr_o       <= '0;
      ccif_o      <= 1'b0;
      ccof_o      <= 1'b0;
    end else begin
      lvl_prev_p2 <= lvl;
      psc_cnt     <= psc_nxt;
      capture_o   <= cap;
      if (cap) begin
        ccr_o <= cnt_i;
      end
      // Set beats clear on both flags.
      if (cap) begin
        ccif_o <= 1'b1;
      end else if (ccif_clr_i) begin
        ccif_o <= 1'b0;
      end
      if (cap && ccif_o && !ccif_clr_i) begin
        ccof_o <= 1'b1;
      end else if (ccof_clr_i) begin
        ccof_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_capture_unit.sv
module tb_input_capture_unit;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic [W-1:0] cnt_i = '0;
  logic         ti_i = 1'b0;
  logic         cce_i = 1'b0;
  logic [1:0]   ccp_i = 2'b00;
  logic [1:0]   icps_i = 2'b00;
  logic [3:0]   icf_i = 4'd0;
  logic         ccg_i = 1'b0;
  logic         ccif_clr_i = 1'b0;
  logic         ccof_clr_i = 1'b0;
  logic [W-1:0] ccr_o;
  logic         ccif_o;
  logic         ccof_o;
  logic         capture_o;

  input_capture_unit #(.CNT_WIDTH(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .cnt_i(cnt_i), .ti_i(ti_i),
    .cce_i(cce_i), .ccp_i(ccp_i), .icps_i(icps_i), .icf_i(icf_i),
    .ccg_i(ccg_i), .ccif_clr_i(ccif_clr_i), .ccof_clr_i(ccof_clr_i),
    .ccr_o(ccr_o), .ccif_o(ccif_o), .ccof_o(ccof_o), .capture_o(capture_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int stepno = 0;
  int ncap = 0;
  int cap_q[$];

  // Reference model state: ti samples since reset, newest at back.
  logic         hist[$];
  logic [W-1:0] m_ccr = '0;
  logic         m_ccif = 1'b0;
  logic         m_ccof = 1'b0;
  logic         m_cap = 1'b0;
  int           m_psc = 0;

  // One clock: advance the model on the edge, observe outputs 1 time unit later.
  task automatic step();
    logic cur, prv, r, f, q, c;
    int   dm1;
    @(posedge clk_i);
    stepno++;
    if (reset_i) begin
      hist.delete();
      m_ccr = '0; m_ccif = 1'b0; m_ccof = 1'b0; m_cap = 1'b0; m_psc = 0;
    end else begin
      // Level seen by the edge detector is ti two edges ago, previous is three ago.
      cur = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      prv = (hist.size() >= 3) ? hist[hist.size()-3] : 1'b0;
      r = cur & ~prv;
      f = ~cur & prv;
      q = (ccp_i == 2'b01) ? f : (ccp_i == 2'b11) ? (r | f) : r;
      dm1 = (1 << icps_i) - 1;
      c = 1'b0;
      if (!cce_i) m_psc = 0;
      else if (ccg_i) begin c = 1'b1; m_psc = 0; end
      else if (q) begin
        if (m_psc >= dm1) begin c = 1'b1; m_psc = 0; end
        else m_psc = m_psc + 1;
      end
      if (c && m_ccif && !ccif_clr_i) m_ccof = 1'b1;
      else if (ccof_clr_i) m_ccof = 1'b0;
      if (c) m_ccif = 1'b1;
      else if (ccif_clr_i) m_ccif = 1'b0;
      if (c) m_ccr = cnt_i;
      m_cap = c;
      hist.push_back(ti_i);
      if (hist.size() > 3) void'(hist.pop_front());
    end
    #1;
    cnt_i = cnt_i + 1;
    if (capture_o === 1'b1) begin
      ncap++;
      cap_q.push_back(stepno);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1; ti_i = 1'b0; ccg_i = 1'b0; ccif_clr_i = 1'b0; ccof_clr_i = 1'b0;
    cce_i = 1'b1; ccp_i = 2'b00; icps_i = 2'b00; icf_i = 4'd0;
    step(); step();
    reset_i = 1'b0;
    repeat (3) step();
    cap_q.delete();
  endtask

  task automatic pulse(input int hi, input int lo);
    ti_i = 1'b1;
    repeat (hi) step();
    ti_i = 1'b0;
    repeat (lo) step();
  endtask

  task automatic test_reset();
    reset_i = 1'b1; ti_i = 1'b1; cce_i = 1'b1; ccg_i = 1'b1; cnt_i = 32'h1234_5678;
    step(); step();
    total++; if (capture_o !== 1'b0) begin bad++; $display("FAIL reset_capture got=%b exp=0", capture_o); end
    total++; if (ccif_o !== 1'b0) begin bad++; $display("FAIL reset_ccif got=%b exp=0", ccif_o); end
    total++; if (ccof_o !== 1'b0) begin bad++; $display("FAIL reset_ccof got=%b exp=0", ccof_o); end
    total++; if (ccr_o !== '0) begin bad++; $display("FAIL reset_ccr got=%0h exp=0", ccr_o); end
    ccg_i = 1'b0; reset_i = 1'b0;
    step();
    total++; if (capture_o !== 1'b0) begin bad++; $display("FAIL reset_release_capture got=%b exp=0", capture_o); end
  endtask

  task automatic test_basic_capture();
    do_reset();
    ti_i = 1'b1; cnt_i = 32'd100;
    step();
    total++; if (capture_o !== 1'b0) begin bad++; $display("FAIL basic_edge1 got=%b exp=0", capture_o); end
    step();
    total++; if (capture_o !== 1'b0) begin bad++; $display("FAIL basic_edge2 got=%b exp=0", capture_o); end
    step();
    total++; if (capture_o !== 1'b1) begin bad++; $display("FAIL basic_edge3 got=%b exp=1", capture_o); end
    total++; if (ccr_o !== 32'd102) begin bad++; $display("FAIL basic_ccr got=%0d exp=102", ccr_o); end
    total++; if (ccif_o !== 1'b1) begin bad++; $display("FAIL basic_ccif got=%b exp=1", ccif_o); end
    step();
    total++; if (capture_o !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%b exp=0", capture_o); end
  endtask

  task automatic test_prescaler();
    int n0, base;
    do_reset();
    icps_i = 2'b10;
    n0 = ncap; base = stepno;
    repeat (4) pulse(3, 3);
    total++; if (ncap - n0 !== 1) begin bad++; $display("FAIL psc_four_edges got=%0d exp=1", ncap - n0); end
    total++; if (cap_q.size() < 1 || cap_q[0] - base !== 21) begin
      bad++; $display("FAIL psc_capture_step got=%0d exp=21", (cap_q.size() > 0) ? cap_q[0] - base : -1);
    end
    repeat (3) pulse(3, 3);
    total++; if (ncap - n0 !== 1) begin bad++; $display("FAIL psc_count_cleared got=%0d exp=1", ncap - n0); end
    pulse(3, 3);
    total++; if (ncap - n0 !== 2) begin bad++; $display("FAIL psc_eighth_edge got=%0d exp=2", ncap - n0); end
  endtask

  task automatic test_overcapture();
    do_reset();
    ccg_i = 1'b1; step(); ccg_i = 1'b0; step();
    total++; if ({ccif_o, ccof_o} !== 2'b10) begin bad++; $display("FAIL ovc_first got=%b exp=10", {ccif_o, ccof_o}); end
    ccg_i = 1'b1; step(); ccg_i = 1'b0; step();
    total++; if ({ccif_o, ccof_o} !== 2'b11) begin bad++; $display("FAIL ovc_second got=%b exp=11", {ccif_o, ccof_o}); end
    ccif_clr_i = 1'b1; ccof_clr_i = 1'b1; step(); ccif_clr_i = 1'b0; ccof_clr_i = 1'b0; step();
    total++; if ({ccif_o, ccof_o} !== 2'b00) begin bad++; $display("FAIL ovc_clear got=%b exp=00", {ccif_o, ccof_o}); end
    ccg_i = 1'b1; step();
    ccif_clr_i = 1'b1; step();
    total++; if ({capture_o, ccif_o, ccof_o} !== 3'b110) begin
      bad++; $display("FAIL ovc_clr_same_cycle got=%b exp=110", {capture_o, ccif_o, ccof_o});
    end
    ccif_clr_i = 1'b0; ccof_clr_i = 1'b1; step();
    total++; if (ccof_o !== 1'b1) begin bad++; $display("FAIL ovc_set_beats_clr got=%b exp=1", ccof_o); end
    ccg_i = 1'b0; ccof_clr_i = 1'b0; step();
  endtask

  task automatic test_both_edges();
    int base, n0;
    logic [W-1:0] saved;
    do_reset();
    ccp_i = 2'b11;
    base = stepno;
    pulse(5, 6);
    total++; if (cap_q.size() !== 2) begin bad++; $display("FAIL both_count got=%0d exp=2", cap_q.size()); end
    else begin
      total++; if (cap_q[1] - cap_q[0] !== 5) begin bad++; $display("FAIL both_spacing got=%0d exp=5", cap_q[1] - cap_q[0]); end
      total++; if (cap_q[0] - base !== 3) begin bad++; $display("FAIL both_latency got=%0d exp=3", cap_q[0] - base); end
    end
    cce_i = 1'b0; ccg_i = 1'b1; saved = ccr_o; n0 = ncap;
    step(); ccg_i = 1'b0;
    pulse(5, 6);
    total++; if (ncap !== n0) begin bad++; $display("FAIL disabled_captures got=%0d exp=0", ncap - n0); end
    total++; if (ccr_o !== saved) begin bad++; $display("FAIL disabled_ccr got=%0h exp=%0h", ccr_o, saved); end
    total++; if (ccif_o !== 1'b1) begin bad++; $display("FAIL disabled_ccif got=%b exp=1", ccif_o); end
    cce_i = 1'b1;
  endtask

  task automatic test_reset_mid_prescale();
    int n0, found;
    do_reset();
    ccg_i = 1'b1; step(); ccg_i = 1'b0; step();
    icps_i = 2'b11;
    n0 = ncap;
    pulse(2, 2); pulse(2, 2);
    total++; if (ncap !== n0) begin bad++; $display("FAIL midpsc_no_capture got=%0d exp=0", ncap - n0); end
    reset_i = 1'b1; step(); reset_i = 1'b0;
    total++; if ({capture_o, ccif_o, ccof_o} !== 3'b000 || ccr_o !== '0) begin
      bad++; $display("FAIL midpsc_reset_outputs got=%b/%0h exp=000/0", {capture_o, ccif_o, ccof_o}, ccr_o);
    end
    n0 = ncap; found = 0;
    for (int k = 1; k <= 10; k++) begin
      pulse(2, 2);
      if (found == 0 && ncap > n0) found = k;
    end
    total++; if (found !== 8) begin bad++; $display("FAIL midpsc_edges_needed got=%0d exp=8", found); end
  endtask

`ifdef IC_FILTER_EN
  task automatic test_filter();
    int n0, base;
    do_reset();
    icf_i = 4'd4;
    repeat (3) step();
    n0 = ncap;
    pulse(3, 12);
    total++; if (ncap !== n0) begin bad++; $display("FAIL filter_glitch got=%0d exp=0", ncap - n0); end
    cap_q.delete(); base = stepno;
    pulse(6, 12);
    total++; if (cap_q.size() < 1 || cap_q[0] - base !== 7) begin
      bad++; $display("FAIL filter_latency got=%0d exp=7", (cap_q.size() > 0) ? cap_q[0] - base : -1);
    end
    icf_i = 4'd0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ti_i = ~ti_i;
      reset_i    = ($urandom_range(0, 199) == 0);
      cce_i      = ($urandom_range(0, 9) != 0);
      ccg_i      = ($urandom_range(0, 24) == 0);
      ccif_clr_i = ($urandom_range(0, 9) == 0);
      ccof_clr_i = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) icps_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) ccp_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) cnt_i = $urandom;
      step();
      total++;
      if ({capture_o, ccif_o, ccof_o, ccr_o} !== {m_cap, m_ccif, m_ccof, m_ccr}) begin
        bad++;
        $display("FAIL random_cycle%0d got=%b%b%b/%0h exp=%b%b%b/%0h", i,
                 capture_o, ccif_o, ccof_o, ccr_o, m_cap, m_ccif, m_ccof, m_ccr);
      end
    end
    reset_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_prescaler();
    test_overcapture();
    test_both_edges();
    test_reset_mid_prescale();
`ifdef IC_FILTER_EN
    test_filter();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
